// File: rtl/hm10_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hm10_pkg
// Description : Shared constants for the HM-10 BLE sender/receiver pair.
// Revision    : 1.0 - initial release
// ============================================================================
package hm10_pkg;

    localparam int HM10_CLOCK_FREQ = 50_000_000;
    localparam int HM10_BAUD       = 9600;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    localparam logic [31:0] CMD_FEED = 32'h4645_4544;  // "FEED"
    localparam logic [31:0] CMD_STAT = 32'h5354_4154;  // "STAT"

    localparam logic [2:0] RX_IDLE  = 3'd0;
    localparam logic [2:0] RX_START = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] RX_STOP  = 3'd3;
    localparam logic [2:0] RX_BREAK = 3'd4;

    function automatic logic is_terminator(input logic [7:0] b);
        return (b == CR) || (b == LF);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hm10_receiver_uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_core
// Description : 8N1 UART receiver with 2-flop input synchronizer and break hold.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_core
    import hm10_pkg::*;
#(
    parameter int CLOCK_FREQ = HM10_CLOCK_FREQ,
    parameter int BAUD       = HM10_BAUD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] C_HALF = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(CLKS_PER_BIT);

    logic [1:0]       r_sync;
    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_data_out;
    logic             r_data_valid;
    logic             r_frame_err;

    logic             w_rx_s;
    logic [CNT_W-1:0] w_cnt_next;

    assign w_rx_s     = r_sync[1];
    assign w_cnt_next = r_cnt + CNT_W'(1);

    // Comparing the incremented count makes the decision land exactly
    // CLKS_PER_BIT/2 (then CLKS_PER_BIT) cycles after the counter was cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync       <= 2'b11;
            r_state      <= RX_IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_sync       <= {r_sync[0], rx};
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    r_cnt     <= '0;
                    r_bit_idx <= '0;
                    if (!w_rx_s)
                        r_state <= RX_START;
                end
                RX_START: begin
                    if (w_cnt_next == C_HALF) begin
                        r_cnt   <= '0;
                        r_state <= w_rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                RX_DATA: begin
                    if (w_cnt_next == C_FULL) begin
                        r_cnt     <= '0;
                        r_shift   <= {w_rx_s, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7)
                            r_state <= RX_STOP;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                RX_STOP: begin
                    if (w_cnt_next == C_FULL) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            r_data_out   <= r_shift;
                            r_data_valid <= 1'b1;
                            r_state      <= RX_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= RX_BREAK;
                        end
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                RX_BREAK: begin
                    if (w_rx_s)
                        r_state <= RX_IDLE;
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: rtl/hm10_receiver.sv
`default_nettype none
// ============================================================================
// Module      : hm10_receiver
// Description : HM-10 downlink UART receiver plus FEED/STAT line decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module hm10_receiver
    import hm10_pkg::*;
#(
    parameter int CLOCK_FREQ = HM10_CLOCK_FREQ,
    parameter int BAUD       = HM10_BAUD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       cmd_feed,
    output logic       cmd_status,
    output logic       cmd_unknown
);

    logic [7:0]  w_byte;
    logic        w_valid;
    logic        w_ferr;

    logic [31:0] r_buf;
    logic [2:0]  r_len;
    logic        r_ovf;
    logic        r_cmd_feed;
    logic        r_cmd_status;
    logic        r_cmd_unknown;

    uart_rx_core #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD       (BAUD)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .data_out   (w_byte),
        .data_valid (w_valid),
        .frame_err  (w_ferr)
    );

    // First character of a line ends up in the MSB byte, matching the literals.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf         <= '0;
            r_len         <= '0;
            r_ovf         <= 1'b0;
            r_cmd_feed    <= 1'b0;
            r_cmd_status  <= 1'b0;
            r_cmd_unknown <= 1'b0;
        end else begin
            r_cmd_feed    <= 1'b0;
            r_cmd_status  <= 1'b0;
            r_cmd_unknown <= 1'b0;
            if (w_ferr) begin
                r_buf <= '0;
                r_len <= '0;
                r_ovf <= 1'b0;
            end else if (w_valid) begin
                if (is_terminator(w_byte)) begin
                    if (r_len == 3'd0 && !r_ovf) begin
                        // empty line, e.g. LF of a CRLF pair
                    end else if (!r_ovf && r_len == 3'd4 && r_buf == CMD_FEED) begin
                        r_cmd_feed <= 1'b1;
                    end else if (!r_ovf && r_len == 3'd4 && r_buf == CMD_STAT) begin
                        r_cmd_status <= 1'b1;
                    end else begin
                        r_cmd_unknown <= 1'b1;
                    end
                    r_buf <= '0;
                    r_len <= '0;
                    r_ovf <= 1'b0;
                end else if (r_len == 3'd4) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_buf <= {r_buf[23:0], w_byte};
                    r_len <= r_len + 3'd1;
                end
            end
        end
    end

    assign data_out    = w_byte;
    assign data_valid  = w_valid;
    assign frame_err   = w_ferr;
    assign cmd_feed    = r_cmd_feed;
    assign cmd_status  = r_cmd_status;
    assign cmd_unknown = r_cmd_unknown;

endmodule
`default_nettype wire

// File: tb/tb_hm10_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_hm10_receiver
// Description : Scoreboard bench for hm10_receiver at 10 clocks per bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hm10_receiver;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       cmd_feed;
    logic       cmd_status;
    logic       cmd_unknown;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         is_err;
        logic [7:0] val;
    } ev_t;

    ev_t        exp_ev[$];
    int         exp_cmd[$];       // 1=feed 2=status 3=unknown
    logic [7:0] mline[$];
    logic [7:0] last_good;
    int         cyc = 0;
    int         last_dv_cyc = -10;
    time        last_dv_t = 0;

    hm10_receiver #(
        .CLOCK_FREQ (1_000_000),
        .BAUD       (100_000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (rx),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .frame_err   (frame_err),
        .cmd_feed    (cmd_feed),
        .cmd_status  (cmd_status),
        .cmd_unknown (cmd_unknown)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: whole lines are judged by their text once terminated.
    task automatic model_byte(input logic [7:0] b);
        int code;
        exp_ev.push_back('{1'b0, b});
        last_good = b;
        if (b == 8'h0D || b == 8'h0A) begin
            if (mline.size() != 0) begin
                code = 3;
                if (mline.size() == 4) begin
                    if ({mline[0], mline[1], mline[2], mline[3]} == 32'h4645_4544) code = 1;
                    if ({mline[0], mline[1], mline[2], mline[3]} == 32'h5354_4154) code = 2;
                end
                exp_cmd.push_back(code);
            end
            mline.delete();
        end else begin
            mline.push_back(b);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input int bit_ns, input logic stop_v,
                              input bit shape0);
        rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            if (i == 0 && shape0) begin
                rx = ~b[0]; #40;
                rx = b[0];  #50;
                rx = ~b[0]; #10;
            end else begin
                rx = b[i];
                #(bit_ns);
            end
        end
        rx = stop_v;
        #(bit_ns);
    endtask

    task automatic tx_byte(input logic [7:0] b, input int bit_ns);
        model_byte(b);
        send_frame(b, bit_ns, 1'b1, 1'b0);
        rx = 1'b1;
        #(20 + 10 * $urandom_range(0, 3));
    endtask

    task automatic tx_str(input string s, input int bit_ns);
        for (int i = 0; i < s.len(); i++)
            tx_byte(s[i], bit_ns);
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes.
    always @(negedge clk) begin
        int n;
        int code;
        ev_t e;
        cyc++;
        if (rst_n) begin
            n = int'(cmd_feed) + int'(cmd_status) + int'(cmd_unknown);
            if (n != 0) begin
                code = cmd_feed ? 1 : (cmd_status ? 2 : 3);
                chk("cmd_onehot", n, 1);
                chk("cmd_latency", cyc - last_dv_cyc, 1);
                if (exp_cmd.size() == 0) begin
                    chk("cmd_unexpected", code, 0);
                end else begin
                    chk("cmd_code", code, exp_cmd.pop_front());
                end
            end
            if (data_valid && frame_err) chk("dv_and_ferr", 1, 0);
            if (data_valid || frame_err) begin
                if (exp_ev.size() == 0) begin
                    chk("event_unexpected", {data_valid, frame_err}, 0);
                end else begin
                    e = exp_ev.pop_front();
                    chk(data_valid ? "data_byte" : "frame_err_data", data_out, e.val);
                    chk("event_kind", frame_err, e.is_err);
                end
            end
            if (data_valid) begin
                last_dv_cyc = cyc;
                last_dv_t   = $time;
            end
        end
    end

    initial begin
        string      lines[8];
        logic [7:0] b46;
        time        fall_t;
        int         k;

        lines[0] = "FEED"; lines[1] = "STAT"; lines[2] = "FEEDX"; lines[3] = "fe";
        lines[4] = "FEE";  lines[5] = "STATS"; lines[6] = "";     lines[7] = "Feed";
        last_good = 8'h00;
        rx = 1'b1;
        rst_n = 1'b0;
        #33;
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_strobes", {data_valid, frame_err, cmd_feed, cmd_status, cmd_unknown}, 0);
        #27 rst_n = 1'b1;
        #40;

        // 0xA5 with bit 0 only valid near its centre, plus strobe latency.
        model_byte(8'hA5);
        fall_t = $time;
        send_frame(8'hA5, 100, 1'b1, 1'b1);
        rx = 1'b1;
        #50;
        chk("a5_dv_latency_ok", ((last_dv_t - fall_t) / 10 >= 97 && (last_dv_t - fall_t) / 10 <= 99), 1);

        tx_str("FEED", 100); tx_byte(8'h0D, 100); tx_byte(8'h0A, 100);
        tx_str("STAT", 100); tx_byte(8'h0A, 100);
        tx_str("FEEDX", 100); tx_byte(8'h0A, 100);
        tx_str("fe", 100); tx_byte(8'h0A, 100);

        // short glitch must be rejected silently
        rx = 1'b0; #30; rx = 1'b1; #300;

        // bad stop bit followed by a held-low line
        exp_ev.push_back('{1'b1, last_good});
        mline.delete();
        send_frame(8'h55, 100, 1'b0, 1'b0);
        #400 rx = 1'b1;
        #100;
        tx_byte(8'h31, 100);
        tx_byte(8'h0A, 100);

        // reset during bit 4 of 'F' after "FEE"
        tx_str("FEE", 100);
        b46 = 8'h46;
        rx = 1'b0; #100;
        for (int i = 0; i < 4; i++) begin
            rx = b46[i];
            #100;
        end
        rx = b46[4];
        #50 rst_n = 1'b0;
        #4;
        chk("abort_data_out", data_out, 8'h00);
        chk("abort_strobes", {data_valid, frame_err, cmd_feed, cmd_status, cmd_unknown}, 0);
        chk("abort_pending", exp_ev.size() + exp_cmd.size(), 0);
        rx = 1'b1;
        #26 rst_n = 1'b1;
        mline.delete();
        last_good = 8'h00;
        #100;
        tx_str("FEED", 100); tx_byte(8'h0A, 100);

        // transmitter 2% slow
        tx_byte(8'h00, 102); tx_byte(8'hFF, 102); tx_byte(8'h3C, 102);
        tx_byte(8'h0A, 100);

        // randomized lines and bytes at up to +-2% skew
        for (int it = 0; it < 30; it++) begin
            k = 98 + $urandom_range(0, 4);
            if ($urandom_range(0, 3) == 0) begin
                tx_byte(8'($urandom_range(0, 255)), k);
            end else begin
                tx_str(lines[$urandom_range(0, 7)], k);
                case ($urandom_range(0, 2))
                    0:       tx_byte(8'h0D, k);
                    1:       tx_byte(8'h0A, k);
                    default: begin tx_byte(8'h0D, k); tx_byte(8'h0A, k); end
                endcase
            end
        end

        for (int t = 0; t < 2000 && (exp_ev.size() + exp_cmd.size()) != 0; t++)
            @(posedge clk);
        #20;
        chk("drain_events", exp_ev.size(), 0);
        chk("drain_cmds", exp_cmd.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
